// File: rtl/pc.sv
// pc: program counter for the nand_to_cpu datapath.
// Each cycle the counter clears, loads a jump target, increments, or holds.
// The priority order is rst > clr > stall > load > inc > hold.
// The optional `stall` input is present only when the PC_STALL_EN macro is defined.
// Without PC_STALL_EN the counter behaves as if `stall` were tied low.
// Both outputs come straight from flops, so no input reaches q or wrap combinationally.
module pc #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
`ifdef PC_STALL_EN
    input  logic             stall,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_stall;
    logic             w_all_ones;
    logic [WIDTH-1:0] w_q_inc;

    // Freeze request: a real input when the feature is built in, otherwise always low.
`ifdef PC_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Increment datapath.
    // The carry out of the MSB is dropped from q and is reported only through wrap.
    assign w_q_inc    = r_q + ONE;
    assign w_all_ones = &r_q;

    // Next-state selection in strict priority order.
    // A stall blocks load and inc, but a clear still takes effect.
    // Only an increment from all-ones can raise wrap; a load of all-ones never does.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (clr) begin
            w_q_next = ZERO;
        end else if (w_stall) begin
            w_q_next = r_q;
        end else if (load) begin
            w_q_next = d;
        end else if (inc) begin
            w_q_next    = w_q_inc;
            w_wrap_next = w_all_ones;
        end
    end

    // State registers.
    // Reset overrides immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_pc.sv
// tb_pc: directed self-checking bench for the program counter.
// The stall vectors are compiled in only when PC_STALL_EN is defined.
`timescale 1ns/1ps
module tb_pc;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             load;
    logic             inc;
`ifdef PC_STALL_EN
    logic             stall;
`endif
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             wrap;

    int n_checks;
    int n_errors;

    pc #(
        .WIDTH     (WIDTH),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .load  (load),
        .inc   (inc),
`ifdef PC_STALL_EN
        .stall (stall),
`endif
        .d     (d),
        .q     (q),
        .wrap  (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and report the result on one line.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before anything is driven or sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Set the control inputs and the jump target in one call.
    task automatic drive(input logic c, input logic l, input logic i, input logic [WIDTH-1:0] dv);
        clr  = c;
        load = l;
        inc  = i;
        d    = dv;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef PC_STALL_EN
        stall = 1'b0;
`endif
        step();
        check("reset_q", q, 32'h0);
        check("reset_wrap", wrap, 32'h0);
        rst = 1'b0;

        // Asynchronous reset asserted mid-cycle, with no clock edge.
        drive(1'b0, 1'b1, 1'b0, 16'h1234);
        step();
        check("load_1234", q, 32'h1234);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", q, 32'h0);
        check("async_rst_wrap", wrap, 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("inc_after_rst", q, 32'h1);

        // Increment run starting from 0.
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check("clr_to_0", q, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("inc_run_q%0d", i), q, 32'(i));
            check($sformatf("inc_run_wrap%0d", i), wrap, 32'h0);
        end

        // Wrap from all-ones to zero.
        drive(1'b0, 1'b1, 1'b0, 16'hFFFE);
        step();
        check("load_fffe", q, 32'hFFFE);
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("inc_ffff", q, 32'hFFFF);
        check("inc_ffff_wrap", wrap, 32'h0);
        step();
        check("wrap_q0", q, 32'h0);
        check("wrap_pulse", wrap, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check("wrap_fall_q", q, 32'h0);
        check("wrap_fall", wrap, 32'h0);

        // Priority between simultaneous controls.
        drive(1'b0, 1'b1, 1'b1, 16'h0100);
        step();
        check("load_over_inc", q, 32'h0100);
        drive(1'b1, 1'b1, 1'b0, 16'h0200);
        step();
        check("clr_over_load", q, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 16'hFFFF);
        step();
        check("load_ffff_q", q, 32'hFFFF);
        check("load_ffff_nowrap", wrap, 32'h0);
        // A load of all-ones and then an increment must wrap.
        // d is driven with a value that must be ignored.
        drive(1'b0, 1'b0, 1'b1, 16'h5555);
        step();
        check("inc_from_loaded_ffff", q, 32'h0);
        check("wrap_after_loaded_ffff", wrap, 32'h1);
        // A clear in the cycle after a wrap must drop the pulse.
        drive(1'b1, 1'b0, 1'b1, 16'h0000);
        step();
        check("clr_drops_wrap", wrap, 32'h0);

        // Hold, then reset during an increment cycle.
        drive(1'b0, 1'b1, 1'b0, 16'h00AA);
        step();
        check("load_00aa", q, 32'h00AA);
        drive(1'b0, 1'b0, 1'b0, 16'h0F0F);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_%0d", i), q, 32'h00AA);
        end
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check("midop_rst_q", q, 32'h0);
        step();
        check("rst_held_ignores_inc", q, 32'h0);
        rst = 1'b0;
        step();
        check("inc_after_midop_rst", q, 32'h1);

`ifdef PC_STALL_EN
        // Stall blocks load and inc but not clr.
        drive(1'b0, 1'b1, 1'b0, 16'h0010);
        step();
        check("load_0010", q, 32'h0010);
        stall = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("stall_blocks_inc", q, 32'h0010);
        drive(1'b0, 1'b1, 1'b0, 16'h0300);
        step();
        check("stall_blocks_load", q, 32'h0010);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check("stall_clr", q, 32'h0);
        stall = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        step();
        check("unstall_inc", q, 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc.md
# pc

16-bit program counter for the nand_to_cpu datapath. Holds the address of the current instruction. Each cycle it can clear, load a jump target, increment, or hold. It sits directly downstream of the gate library (inverters, AND/OR, mux) and of the ALU jump-condition logic, and drives the instruction-memory address bus.

## Interface

Parameters:
- `WIDTH`, 16, counter width in bits (≥2).
- `RESET_VAL`, 0, value of `q` after asynchronous reset (`WIDTH` bits).

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `clr`  input  1  synchronous clear to 0.
- `load`  input  1  synchronous load of `d` (jump).
- `inc`  input  1  synchronous increment by 1.
- `d`  input  `WIDTH`  jump target.
- `q`  output  `WIDTH`  current counter value (registered).
- `wrap`  output  1  registered pulse; high for exactly one cycle after an increment from all-ones to 0.
- `stall`  input  1  freeze request (present only with `PC_STALL_EN`).

## Operation

- State: one `WIDTH`-bit register `q` and one 1-bit register `wrap`. There is no other state.
- Next-state priority, evaluated at each rising `clk` edge:
  1. `clr=1` → `q←0`, `wrap←0`.
  2. `load=1` → `q←d`, `wrap←0`.
  3. `inc=1` → `q←q+1` modulo 2^`WIDTH`, `wrap←(q==all-ones)`.
  4. Otherwise hold: `q←q`, `wrap←0`.
- Simultaneous controls resolve strictly by this priority:
  - `clr`+`load` → 0.
  - `load`+`inc` → `d`, not `d+1`.
- Increment arithmetic is unsigned, `WIDTH` bits. The carry out of the MSB is discarded from `q` and only reported through `wrap`.
- `load` with `d` equal to all-ones does not set `wrap`. `wrap` reports increments only.
- `d` is sampled only when `load` wins priority. Its value is ignored otherwise.
- Inputs `X`/`Z` are not tolerated. The bench drives all inputs to known values after reset.

## Timing

- Asynchronous reset:
  - While `rst=1`: `q=RESET_VAL` and `wrap=0` immediately, independent of `clk`.
  - All other inputs are ignored while `rst=1`.
- Release of `rst` is synchronous in effect. The first edge with `rst=0` applies the normal priority.
- Reset asserted mid-operation (any cycle, including the cycle of a `load` or a wrap) overrides immediately. No partial update survives.
- Latency:
  - Control and `d` sampled at edge N appear on `q` after edge N, i.e. one cycle.
  - `wrap` rises after the same edge as the 0 value on `q` and falls after the next edge unless another wrap occurs. It cannot occur in back-to-back cycles for `WIDTH`≥2.
- No combinational path from any input to `q` or `wrap`. Both outputs are pure register outputs.
- Hold behaviour: with all controls low, `q` is stable indefinitely.

## Configuration

- Macro: `PC_STALL_EN`.
- Defined:
  - Adds input `stall` (1 bit).
  - When `stall=1`, `load` and `inc` are blocked: `q` holds and `wrap←0`.
  - `clr` and `rst` still take effect during `stall`.
  - Priority becomes `rst` > `clr` > `stall` > `load` > `inc` > hold.
- Undefined:
  - No `stall` port exists.
  - Behaviour is identical to the defined case with `stall` tied to 0.

## Test plan

- Reset: set `rst=1` mid-cycle with `q=0x1234` → `q=0x0000`, `wrap=0` without a clock edge. Release `rst` and pulse `inc` once → `q=0x0001`.
- Increment run: from 0, `inc=1` for 5 edges → `q` reads 1,2,3,4,5 on successive cycles, `wrap=0` throughout.
- Wrap: `load` `d=0xFFFE`, then `inc` for 2 edges → `q=0xFFFF` then `0x0000`. `wrap=1` only in the cycle `q=0x0000`, then 0 on the next edge with `inc=0`.
- Priority:
  - `load=1`, `inc=1`, `d=0x0100` → `q=0x0100`.
  - Next cycle `clr=1`, `load=1`, `d=0x0200` → `q=0x0000`.
  - `load` `d=0xFFFF` → `wrap` stays 0.
- Hold and mid-op reset: `q=0x00AA`, all controls 0 for 3 edges → `q` stays `0x00AA`. Then `rst=1` during an `inc` cycle → `q=RESET_VAL`.
- With `PC_STALL_EN`:
  - `q=0x0010`, `stall=1`, `inc=1` → `q` stays `0x0010`.
  - `stall=1`, `load=1`, `d=0x0300` → `q` stays `0x0010`.
  - `stall=1`, `clr=1` → `q=0x0000`.
